// File: rtl/mem_bus_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_rr
//  Purpose  : Shared memory bus. NPORT cache ports arbitrate for a single
//             internal word-addressed memory with a fixed access latency.
//             Exactly one transaction is in flight at a time. Each
//             transaction is IDLE (grant) -> ACCESS (LATENCY cycles) ->
//             DONE (completion pulse) -> RELEASE -> IDLE.
//  Ports    : clk            - clock, rising edge
//             reset          - synchronous, active-low reset
//             rwFromCache    - 2 bits per port: 01 read, 10 write, else idle
//             addrFromCache  - ADDR_W bits per port
//             dataFromCache  - DATA_W bits per port, write data
//             dataToCache    - DATA_W bits per port, last completed read data
//             rdEnToCache    - per-port one-cycle read-complete pulse
//             wbDoneToCache  - per-port one-cycle write-complete pulse
//             busBusy        - high whenever the FSM is not in IDLE
//             grantId        - port currently or most recently granted
//  Options  : MEMBUS_FIXED_PRIO_EN - when defined, arbitration is fixed
//             priority (lowest index wins) instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_rr #(
    parameter int NPORT   = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [2*NPORT-1:0]                      rwFromCache,
    input  logic [NPORT*ADDR_W-1:0]                 addrFromCache,
    input  logic [NPORT*DATA_W-1:0]                 dataFromCache,
    output logic [NPORT*DATA_W-1:0]                 dataToCache,
    output logic [NPORT-1:0]                        rdEnToCache,
    output logic [NPORT-1:0]                        wbDoneToCache,
    output logic                                    busBusy,
    output logic [((NPORT > 1) ? $clog2(NPORT) : 1)-1:0] grantId
);

    localparam int ID_W   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_id;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_grant_id;
    logic [NPORT-1:0]    r_rd_en;
    logic [NPORT-1:0]    r_wb_done;
    logic [DATA_W-1:0]   r_rdata [NPORT];
    logic [DATA_W-1:0]   r_mem   [DEPTH];
`ifndef MEMBUS_FIXED_PRIO_EN
    logic [ID_W-1:0]     r_rr_ptr;
`endif

    logic [NPORT-1:0]    w_req;
    logic [1:0]          w_rw     [NPORT];
    logic [ADDR_W-1:0]   w_addr   [NPORT];
    logic [DATA_W-1:0]   w_wdata  [NPORT];
    logic                w_req_any;
    logic [ID_W-1:0]     w_win;
    logic                w_commit;
    logic                w_in_range;
    logic [31:0]         w_addr_ext;
    logic [MEM_AW-1:0]   w_mem_idx;

    // Unpack the flat per-port buses; 01 and 10 are the only real requests.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign w_rw[p]    = rwFromCache[2*p +: 2];
        assign w_addr[p]  = addrFromCache[p*ADDR_W +: ADDR_W];
        assign w_wdata[p] = dataFromCache[p*DATA_W +: DATA_W];
        assign w_req[p]   = rwFromCache[2*p] ^ rwFromCache[2*p+1];
        assign dataToCache[p*DATA_W +: DATA_W] = r_rdata[p];
    end

    // Arbiter. Loops run from lowest to highest priority so the last match
    // (the highest-priority requester) is the one that sticks.
    always_comb begin
        w_req_any = 1'b0;
        w_win     = '0;
`ifdef MEMBUS_FIXED_PRIO_EN
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_req_any = 1'b1;
                w_win     = ID_W'(i);
            end
        end
`else
        for (int i = NPORT; i >= 1; i--) begin
            int v_idx;
            v_idx = (int'(r_rr_ptr) + i) % NPORT;
            if (w_req[v_idx]) begin
                w_req_any = 1'b1;
                w_win     = ID_W'(v_idx);
            end
        end
`endif
    end

    // The edge that leaves ACCESS is the edge that performs the memory access.
    assign w_commit   = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_addr_ext = 32'(r_addr);
    assign w_in_range = (w_addr_ext < 32'(DEPTH));
    assign w_mem_idx  = w_addr_ext[MEM_AW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_req_any) w_state_nxt = S_ACCESS;
            S_ACCESS:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_id       <= '0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_grant_id <= '0;
            r_rd_en    <= '0;
            r_wb_done  <= '0;
            for (int p = 0; p < NPORT; p++) r_rdata[p] <= '0;
`ifndef MEMBUS_FIXED_PRIO_EN
            r_rr_ptr   <= ID_W'(NPORT - 1);
`endif
        end else begin
            r_state   <= w_state_nxt;
            // Pulses are only ever set on DONE entry, so clearing every
            // other cycle makes them exactly one cycle wide.
            r_rd_en   <= '0;
            r_wb_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_id       <= w_win;
                        r_grant_id <= w_win;
                        r_op_wr    <= w_rw[w_win][1];
                        r_addr     <= w_addr[w_win];
                        r_data     <= w_wdata[w_win];
                        r_cnt      <= CNT_W'(LATENCY - 1);
`ifndef MEMBUS_FIXED_PRIO_EN
                        r_rr_ptr   <= w_win;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_op_wr) begin
                        r_wb_done[r_id] <= 1'b1;
                    end else begin
                        r_rd_en[r_id] <= 1'b1;
                        r_rdata[r_id] <= w_in_range ? r_mem[w_mem_idx] : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array is never reset; an asserted reset at the commit edge
    // aborts the write along with the rest of the transaction.
    always_ff @(posedge clk) begin
        if (reset && w_commit && r_op_wr && w_in_range) begin
            r_mem[w_mem_idx] <= r_data;
        end
    end

    assign rdEnToCache   = r_rd_en;
    assign wbDoneToCache = r_wb_done;
    assign busBusy       = (r_state != S_IDLE);
    assign grantId       = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_rr
//  Purpose  : Scoreboard bench for mem_bus_rr (NPORT=4, DEPTH=200,
//             LATENCY=2). Stimulus pushes expected completions into a queue;
//             a negedge monitor pops and compares on every completion pulse
//             and tracks the expected dataToCache value of every port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_rr;

    localparam int NPORT   = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 200;
    localparam int LATENCY = 2;
    localparam int ID_W    = 2;

    logic                       clk;
    logic                       reset_n;
    logic [2*NPORT-1:0]         rwFromCache;
    logic [NPORT*ADDR_W-1:0]    addrFromCache;
    logic [NPORT*DATA_W-1:0]    dataFromCache;
    logic [NPORT*DATA_W-1:0]    dataToCache;
    logic [NPORT-1:0]           rdEnToCache;
    logic [NPORT-1:0]           wbDoneToCache;
    logic                       busBusy;
    logic [ID_W-1:0]            grantId;

    logic [1:0]         rw_a   [NPORT];
    logic [ADDR_W-1:0]  addr_a [NPORT];
    logic [DATA_W-1:0]  data_a [NPORT];

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          pulse_cyc[$];
    logic [31:0] shadow [NPORT];
    int          checks;
    int          errors;
    int          cyc;

    mem_bus_rr #(
        .NPORT(NPORT), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset_n),
        .rwFromCache(rwFromCache),
        .addrFromCache(addrFromCache),
        .dataFromCache(dataFromCache),
        .dataToCache(dataToCache),
        .rdEnToCache(rdEnToCache),
        .wbDoneToCache(wbDoneToCache),
        .busBusy(busBusy),
        .grantId(grantId)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rwFromCache   = '0;
        addrFromCache = '0;
        dataFromCache = '0;
        for (int p = 0; p < NPORT; p++) begin
            rwFromCache[2*p +: 2]             = rw_a[p];
            addrFromCache[p*ADDR_W +: ADDR_W] = addr_a[p];
            dataFromCache[p*DATA_W +: DATA_W] = data_a[p];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int p, input bit wr, input logic [31:0] d);
        exp_t e;
        e.port = p; e.wr = wr; e.data = d;
        sb.push_back(e);
    endfunction

    // Requester: hold the request until this port's pulse, then drop it.
    task automatic xfer(input int p, input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] d);
        int t;
        bit seen;
        addr_a[p] = a;
        data_a[p] = d;
        rw_a[p]   = op;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 60) begin
            @(negedge clk);
            t++;
            if (rdEnToCache[p] || wbDoneToCache[p]) seen = 1'b1;
        end
        rw_a[p] = 2'b00;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout port %0d: no completion pulse after %0d cycles", p, t);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [NPORT-1:0] prev_pulse;
        prev_pulse = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int p = 0; p < NPORT; p++) shadow[p] = '0;
                prev_pulse = '0;
            end else begin
                for (int p = 0; p < NPORT; p++) begin
                    logic pulse;
                    pulse = rdEnToCache[p] | wbDoneToCache[p];
                    if (pulse) begin
                        pulse_cyc.push_back(cyc);
                        checks++;
                        if (prev_pulse[p]) begin
                            errors++;
                            $display("FAIL pulse_width port %0d: pulse high for 2+ cycles", p);
                        end
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse port %0d: rd=%0b wb=%0b, none expected",
                                     p, rdEnToCache[p], wbDoneToCache[p]);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            if (e.port != p || wbDoneToCache[p] !== e.wr ||
                                rdEnToCache[p] === e.wr || int'(grantId) != e.port) begin
                                errors++;
                                $display("FAIL completion: got port %0d rd=%0b wb=%0b grant=%0d, expected port %0d wr=%0b",
                                         p, rdEnToCache[p], wbDoneToCache[p], grantId, e.port, e.wr);
                            end
                            if (!e.wr) shadow[p] = e.data;
                        end
                    end
                    prev_pulse[p] = pulse;
                end
                for (int p = 0; p < NPORT; p++) begin
                    checks++;
                    if (dataToCache[p*DATA_W +: DATA_W] !== shadow[p]) begin
                        errors++;
                        $display("FAIL dataToCache[%0d]: got 0x%0h expected 0x%0h",
                                 p, dataToCache[p*DATA_W +: DATA_W], shadow[p]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int issue;
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset_n = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            rw_a[p] = 2'b00; addr_a[p] = '0; data_a[p] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_busBusy", 32'(busBusy), 32'd0);
        check("reset_grantId", 32'(grantId), 32'd0);
        check("reset_rdEn", 32'(rdEnToCache), 32'd0);
        check("reset_wbDone", 32'(wbDoneToCache), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write and its latency, then read back
        pulse_cyc.delete();
        issue = cyc;
        push(0, 1'b1, 32'h0);
        xfer(0, 2'b10, 8'h05, 32'hDEADBEEF);
        check("write_latency", 32'(pulse_cyc[0] - issue), 32'(LATENCY + 1));
        push(0, 1'b0, 32'hDEADBEEF);
        xfer(0, 2'b01, 8'h05, 32'h0);

        // Distinct data in ports 1..3 addresses
        push(1, 1'b1, 32'h0); xfer(1, 2'b10, 8'h06, 32'h11111111);
        push(2, 1'b1, 32'h0); xfer(2, 2'b10, 8'h07, 32'h22222222);
        push(3, 1'b1, 32'h0); xfer(3, 2'b10, 8'h08, 32'h33333333);

        // All four ports read at once, twice: order 0,1,2,3 each round
        pulse_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            push(0, 1'b0, 32'hDEADBEEF);
            push(1, 1'b0, 32'h11111111);
            push(2, 1'b0, 32'h22222222);
            push(3, 1'b0, 32'h33333333);
            fork
                xfer(0, 2'b01, 8'h05, 32'h0);
                xfer(1, 2'b01, 8'h06, 32'h0);
                xfer(2, 2'b01, 8'h07, 32'h0);
                xfer(3, 2'b01, 8'h08, 32'h0);
            join
        end
        check("rr_pulse_count", 32'(pulse_cyc.size()), 32'd8);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("rr_pulse_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(LATENCY + 3));

        // Out of range: write dropped, read returns 0, 0x70 untouched
        push(0, 1'b1, 32'h0); xfer(0, 2'b10, 8'h70, 32'hCAFEF00D);
        push(0, 1'b1, 32'h0); xfer(0, 2'b10, 8'hF0, 32'h00001234);
        push(0, 1'b0, 32'h0); xfer(0, 2'b01, 8'hF0, 32'h0);
        push(0, 1'b0, 32'hCAFEF00D); xfer(0, 2'b01, 8'h70, 32'h0);

        // Cross-port coherence: rrPtr=0 favours port1's write
        push(1, 1'b1, 32'h0);
        push(0, 1'b0, 32'hA5A5A5A5);
        fork
            xfer(1, 2'b10, 8'h10, 32'hA5A5A5A5);
            xfer(0, 2'b01, 8'h10, 32'h0);
        join
        check("coherence_port1_data", dataToCache[1*DATA_W +: DATA_W], 32'h11111111);

        // Reset in the middle of a write
        push(0, 1'b1, 32'h0); xfer(0, 2'b10, 8'h20, 32'h00000011);
        wait_idle();
        check("pre_abort_idle", 32'(busBusy), 32'd0);
        addr_a[2] = 8'h20; data_a[2] = 32'h00000055; rw_a[2] = 2'b10;
        @(negedge clk);
        check("abort_in_access", 32'(busBusy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        rw_a[2] = 2'b00;
        @(negedge clk);
        check("abort_busBusy", 32'(busBusy), 32'd0);
        check("abort_no_pulse", 32'(rdEnToCache | wbDoneToCache), 32'd0);
        check("abort_grantId", 32'(grantId), 32'd0);
        reset_n = 1'b1;
        push(0, 1'b0, 32'h00000011);
        push(3, 1'b0, 32'h00000011);
        fork
            xfer(0, 2'b01, 8'h20, 32'h0);
            xfer(3, 2'b01, 8'h20, 32'h0);
        join

        // Ports 2 and 3 requesting continuously
`ifdef MEMBUS_FIXED_PRIO_EN
        push(2, 1'b0, 32'hA5A5A5A5);
        push(2, 1'b0, 32'hA5A5A5A5);
        push(2, 1'b0, 32'hA5A5A5A5);
        push(3, 1'b0, 32'hCAFEF00D);
`else
        push(2, 1'b0, 32'hA5A5A5A5);
        push(3, 1'b0, 32'hCAFEF00D);
        push(2, 1'b0, 32'hA5A5A5A5);
        push(2, 1'b0, 32'hA5A5A5A5);
`endif
        fork
            begin
                for (int k = 0; k < 3; k++) xfer(2, 2'b01, 8'h10, 32'h0);
            end
            xfer(3, 2'b01, 8'h70, 32'h0);
        join

        wait_idle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(busBusy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_rr.md
Name: mem_bus_rr

Overview:
- Parametrised shared memory bus: N cache ports arbitrate round-robin for one internal word-addressed memory with fixed access latency.
- Generalises the two-port cache-to-memory bus to N ports, adding configurable depth and latency, a release cycle, out-of-range handling and observable grant status.
- Sits between the per-processor caches and main memory. Exactly one transaction is in flight at a time.

Parameters:
- NPORT, 2, number of cache ports (1..8)
- DATA_W, 32, word width
- ADDR_W, 8, address width
- DEPTH, 256, memory words; addresses >= DEPTH are out of range
- LATENCY, 2, ACCESS-state cycles per transaction (>= 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- rwFromCache  in  2*NPORT  per port p, bits [2p+1:2p]: 00 idle, 01 read, 10 write, 11 treated as idle
- addrFromCache  in  NPORT*ADDR_W  per-port address
- dataFromCache  in  NPORT*DATA_W  per-port write data
- dataToCache  out  NPORT*DATA_W  per-port read data
- rdEnToCache  out  NPORT  one-cycle read-complete pulse
- wbDoneToCache  out  NPORT  one-cycle write-complete pulse
- busBusy  out  1  high in any state other than IDLE
- grantId  out  max(1,$clog2(NPORT))  port currently or last granted

Behaviour:
- Reset applies when reset==0 at a rising edge:
  - state=IDLE; all rdEnToCache, wbDoneToCache, dataToCache, busBusy = 0; rrPtr=NPORT-1; grantId=0.
  - Memory contents are not reset; they power up to zero.
- FSM states: IDLE, ACCESS, DONE, RELEASE.
- IDLE:
  - Sample all rw fields. If any is 01 or 10, pick the first requesting port searching rrPtr+1, rrPtr+2, ... (mod NPORT).
  - Latch that port's id, op, addr and data. Set rrPtr=grantId=id. Go to ACCESS with cnt=LATENCY-1.
  - With no request, stay in IDLE.
- ACCESS: decrement cnt each cycle; when cnt==0, go to DONE. Inputs are ignored; only latched values are used.
- Entry to DONE (same edge):
  - Read: dataToCache[id] <= mem[addr], or 0 if addr >= DEPTH; rdEnToCache[id] <= 1.
  - Write: mem[addr] <= data if addr < DEPTH (out-of-range writes are dropped); wbDoneToCache[id] <= 1.
- DONE lasts one cycle, then go to RELEASE; the pulse clears on leaving DONE.
- RELEASE: one cycle, no arbitration, so the requester can drop rw. Then go to IDLE.
- Latency: a request sampled at IDLE edge e0 produces its done pulse in the cycle after edge e0+LATENCY. Total occupancy is LATENCY+3 cycles, including the IDLE sample.
- Requester contract: hold rw/addr/data until the pulse, then drop rw to 00 within one cycle. A rw still asserted in IDLE is a new request.
- dataToCache[p] holds its value until port p's next completed read. Other ports' data outputs are never disturbed.
- Simultaneous requests: exactly one grant per IDLE cycle. A port's request is never lost while held, and it waits at most NPORT-1 transactions.
- Read and write to the same address from different ports: serialised in grant order. A read after a write returns the written data.
- Reset mid-transaction:
  - Aborts the transaction; no pulse is issued.
  - A write not yet committed (reset before DONE entry) is not performed.
  - rrPtr returns to NPORT-1.
- NPORT=1: port 0 is always granted; grantId is 1 bit, always 0.

Optional Feature:
- Macro: MEMBUS_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest port index wins. rrPtr is unused and grantId still reports the winner.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset then single write: port0 rw=10, addr=0x05, data=0xDEADBEEF, LATENCY=2. Required: wbDoneToCache[0] pulses exactly one cycle, 3 cycles after the sampling edge; then a port0 read of 0x05 returns 0xDEADBEEF with rdEnToCache[0] pulsing.
- NPORT=4, all ports request reads at once and hold until done. Required: grant order 0,1,2,3, then 0 again on re-request; each pulse is 5 cycles apart (LATENCY+3).
- Out of range: DEPTH=200, write 0x1234 to addr 0xF0, then read 0xF0. Required: wbDone pulses; the read returns 0 with rdEn pulse; mem[0x70] is unchanged.
- Cross-port coherence: port1 writes 0xA5A5A5A5 to 0x10 while port0 concurrently reads 0x10, with rrPtr favouring port1. Required: port0's read returns 0xA5A5A5A5; dataToCache[1] stays unchanged.
- Reset mid-transaction: drive reset low during ACCESS of a write of 0x55 to 0x20 (old value 0x11). Required: no pulse, busBusy=0, mem[0x20] still reads 0x11, and the next grant goes to port0.
- MEMBUS_FIXED_PRIO_EN defined: ports 2 and 3 request continuously. Required: port2 is granted every transaction while it keeps requesting; port3 is granted only once port2 stops.
